// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the key conditioner.
// Holds the arbiter state encoding, the key-vector geometry and the index of
// every key inside the debounced vector d[11:0] = {control[1:0], number[9:0]}.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam int N_NUM  = 10;
  localparam int N_CTRL = 2;
  localparam int N_KEYS = N_NUM + N_CTRL;

  typedef logic [N_KEYS-1:0] key_vec_t;

  // Key positions inside d
  localparam int KEY_1     = 9;
  localparam int KEY_2     = 8;
  localparam int KEY_3     = 7;
  localparam int KEY_4     = 6;
  localparam int KEY_5     = 5;
  localparam int KEY_6     = 4;
  localparam int KEY_7     = 3;
  localparam int KEY_8     = 2;
  localparam int KEY_9     = 1;
  localparam int KEY_0     = 0;
  localparam int CUR_RIGHT = 10;
  localparam int CUR_LEFT  = 11;

  // True when two or more bits are set: clearing the lowest set bit leaves
  // something behind only if another bit was set.
  function automatic logic multi_hot(input key_vec_t v);
    key_vec_t one;
    one = key_vec_t'(1);
    return (v & (v - one)) != '0;
  endfunction

endpackage

// File: rtl/btn_conditioner_debounce.sv
// Single-bit key front end: 2-flop synchroniser followed by a counter debounce.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_raw    raw asynchronous key level
//   o_level  debounced level (changes only after DEBOUNCE_CYCLES of a
//            persistent mismatch between the synced input and this level)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  // Counter value on which the next mismatching cycle flips the level
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        // Counter would reach DEBOUNCE_CYCLES on this edge: accept new level
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/btn_conditioner.sv
// Key conditioner for the text-LCD cursor/write controller.
// Each of the 12 raw keys is synchronised and debounced; a single-key arbiter
// then passes exactly one accepted key at a time, holding it for at least
// MIN_HOLD cycles so the LCD controller's 31-cycle sampling window sees it.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   number_raw   raw number keys (bit 9 = '1' ... bit 1 = '9', bit 0 = '0')
//   control_raw  raw cursor keys (bit 1 = left, bit 0 = right)
//   number_btn   conditioned number key, one-hot or zero
//   control_btn  conditioned cursor key, one-hot or zero
//   key_valid    high while an accepted key is on number_btn/control_btn
//   multi_press  one-cycle pulse when several debounced keys go active together
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MIN_HOLD        = 40,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_NUM-1:0]  number_raw,
  input  logic [N_CTRL-1:0] control_raw,
  output logic [N_NUM-1:0]  number_btn,
  output logic [N_CTRL-1:0] control_btn,
  output logic              key_valid,
  output logic              multi_press
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MIN_HOLD);

  key_vec_t w_raw;
  key_vec_t w_d;

  assign w_raw = {control_raw, number_raw};

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_raw   (w_raw[g]),
      .o_level (w_d[g])
    );
  end

  state_t           r_state;
  key_vec_t         r_key;
  logic             r_key_valid;
  logic             r_multi;
  logic [CNT_W-1:0] r_hold_cnt;

  state_t           w_state_nxt;
  key_vec_t         w_key_nxt;
  logic             w_valid_nxt;
  logic             w_multi_nxt;
  logic [CNT_W-1:0] w_hold_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_multi     <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_key       <= w_key_nxt;
      r_key_valid <= w_valid_nxt;
      r_multi     <= w_multi_nxt;
      r_hold_cnt  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_valid_nxt = r_key_valid;
    w_multi_nxt = 1'b0;
    w_hold_nxt  = r_hold_cnt;
    unique case (r_state)
      IDLE: begin
        w_key_nxt   = '0;
        w_valid_nxt = 1'b0;
        if (w_d != '0) begin
          if (multi_hot(w_d)) begin
            w_multi_nxt = 1'b1;
            w_state_nxt = LOCKOUT;
          end else begin
            w_key_nxt   = w_d;
            w_valid_nxt = 1'b1;
            w_hold_nxt  = '0;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (r_hold_cnt != HOLD_MAX) begin
          w_hold_nxt = r_hold_cnt + CNT_W'(1);
        end
        // Leave only once the minimum hold has elapsed and the latched key
        // itself has been released; other keys never touch the outputs.
        if ((r_hold_cnt >= HOLD_LAST) && ((r_key & w_d) == '0)) begin
          w_key_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = (w_d == '0) ? IDLE : LOCKOUT;
        end
      end
      LOCKOUT: begin
        w_key_nxt   = '0;
        w_valid_nxt = 1'b0;
        if (w_d == '0) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_key_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign number_btn  = r_key[N_NUM-1:0];
  assign control_btn = r_key[CUR_LEFT:CUR_RIGHT];
  assign key_valid   = r_key_valid;
  assign multi_press = r_multi;

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end for the text-LCD cursor/write controller. Takes the 10 raw number keys and 2 raw cursor keys from the board pins and delivers clean, one-hot, minimum-width key levels.
- Per-bit processing: 2-FF synchroniser, then counter debounce.
- A single-key arbiter then rejects multi-key presses and holds the accepted key long enough for the LCD controller's 31-cycle WRITE/CURSOR window to sample it.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synced cycles a new level must persist before it is accepted (≥2).
- MIN_HOLD, 40: minimum cycles an accepted key stays asserted on the outputs (must be >31).
- CNT_W, 8: width of the debounce and hold counters (must hold max(DEBOUNCE_CYCLES, MIN_HOLD)).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- number_raw  in  10  raw number keys, active-high. Bit 9 = '1', bit 8 = '2' … bit 1 = '9', bit 0 = '0'.
- control_raw  in  2  raw cursor keys, active-high. Bit 1 = left, bit 0 = right.
- number_btn  out  10  conditioned number key, one-hot or zero, registered.
- control_btn  out  2  conditioned cursor key, one-hot or zero, registered.
- key_valid  out  1  high while an accepted key is driven on number_btn/control_btn.
- multi_press  out  1  one-cycle pulse when more than one debounced key goes active at once.

Behaviour:
- Reset (async, rst=0):
  - All synchroniser flops, debounced levels, counters and outputs go to 0.
  - State goes to IDLE.
  - Outputs are 0 immediately, not at the next clock edge.
- Synchroniser: 2 flops per bit; sync2 is the synchronised level.
- Debounce, per bit:
  - Counter clears whenever sync2 == debounced level.
  - Counter increments while they differ.
  - The debounced level toggles on the edge where the counter would reach DEBOUNCE_CYCLES, and the counter clears.
  - A mismatch shorter than DEBOUNCE_CYCLES produces no change.
- Vector d[11:0] = {debounced control, debounced number}.
- Arbiter FSM, all outputs registered:
  - IDLE: outputs 0, key_valid=0.
    - Exactly one bit of d set: latch it into the output register, key_valid=1, clear the hold counter, go to HOLD.
    - Two or more bits set on the same cycle: multi_press=1 for that cycle, go to LOCKOUT.
    - d=0: stay.
  - HOLD: outputs keep the latched key; hold counter increments and saturates at MIN_HOLD.
    - Exit only when hold counter ≥ MIN_HOLD−1 AND the latched bit of d is 0.
    - On exit, if d==0: go to IDLE and clear the outputs that same edge.
    - On exit, if d≠0 (another key still held): go to LOCKOUT and clear the outputs.
    - Other keys pressed during HOLD are ignored; they never alter the outputs.
  - LOCKOUT: outputs 0, key_valid=0; go to IDLE when d==0.
- Latency: first raw sample of a new stable level → output asserted on rising edge DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES debounce + 1 output register).
- Release mirrors press latency, but assertion never shortens below MIN_HOLD cycles.
- Output invariant: number_btn and control_btn together carry at most one set bit on every cycle.
- A key held through reset release is treated as a fresh press: it is debounced from 0 and then accepted.
- multi_press is never asserted in HOLD or LOCKOUT.

Decomposition:
- Package btn_pkg:
  - FSM state encoding: IDLE, HOLD, LOCKOUT (2 bits).
  - N_NUM=10 and N_CTRL=2.
  - Key index constants: KEY_1=9 … KEY_9=1, KEY_0=0, CUR_LEFT=11, CUR_RIGHT=10 in d.
- Sub-module btn_debounce: single bit with synchroniser, counter and debounced level, parameterised on DEBOUNCE_CYCLES/CNT_W. Instantiated 12 times.
- The arbiter FSM stays in the top level.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=16, MIN_HOLD=40, clk period 10 ns.
1. Reset with number_raw=10'h000 → all outputs 0. Assert rst low mid-HOLD → outputs 0 within the same cycle, with no clock edge needed.
2. Press number_raw=10'b00_0000_0001 for 100 cycles, then release:
   - number_btn=10'b00_0000_0001 and key_valid=1 from edge 19 after the press.
   - Both deassert on edge 19 after the release.
   - multi_press never fires.
3. Glitch: number_raw bit 9 high for 10 cycles, then low → number_btn stays 10'h000 and key_valid stays 0.
4. Short press: control_raw=2'b10 for 20 cycles → control_btn=2'b10 asserted for exactly 40 cycles, then 0.
5. Multi-press: number_raw=10'b10_0000_0001 (bits 9 and 0 applied together) → multi_press pulses high 1 cycle at edge 19. Outputs stay 0 until both keys are released and debounced. A subsequent press of 10'b00_0000_0010 is accepted normally.
6. Interfering key: hold number_raw=10'b01_0000_0000; at cycle 30 add control_raw=2'b01 and keep it after number release:
   - number_btn stays 10'b01_0000_0000 until its release exit.
   - control_btn never asserts; the FSM passes through LOCKOUT.
   - It returns to IDLE once control_raw is released.
